restoring_divider_32_bit: RTL
=============================

RESTORING_DIVIDER_32_BIT -- requirements
Module: restoring_divider_32_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk SHALL be an input, 1 bit wide: the only clock, rising-edge active.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-005 Port start SHALL be an input, 1 bit wide: request to begin a division, sampled only in IDLE.
REQ-006 Port dividend SHALL be an input, WIDTH bits wide: the numerator, captured on an accepted start.
REQ-007 Port divisor SHALL be an input, WIDTH bits wide: the denominator, captured on an accepted start.
REQ-008 Port busy SHALL be an output, 1 bit wide: high whenever the state is not IDLE.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle pulse marking valid results.
REQ-010 Port quotient SHALL be an output, WIDTH bits wide: the registered result.
REQ-011 Port remainder SHALL be an output, WIDTH bits wide: the registered result.
REQ-012 Port div_by_zero SHALL be an output, 1 bit wide: registered flag, valid while the results are valid.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 SHALL capture both operands, clear the partial remainder and the iteration counter, and transition as follows:
- divisor==0: go to DONE;
- otherwise: go to RUN.
REQ-015 RUN SHALL perform one restoring step per cycle:
- shift {partial remainder, quotient} left by 1;
- trial-subtract the divisor from the partial remainder;
- if no borrow: keep the difference and set quotient bit 0 to 1;
- if borrow: restore the partial remainder and set quotient bit 0 to 0.
REQ-016 RUN SHALL last exactly WIDTH cycles, with a counter of width clog2(WIDTH)+1, then go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency SHALL be fixed: start accepted at edge k gives done high during the cycle after edge k+WIDTH+1 (k+33 for WIDTH=32); divide-by-zero completes after edge k+1.
REQ-019 Divide-by-zero SHALL give quotient = all ones, remainder = dividend and div_by_zero=1.
REQ-020 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new operation is accepted in IDLE only.
REQ-022 quotient, remainder and div_by_zero SHALL update only in DONE and hold their values until the next DONE.
REQ-023 Operands SHALL be treated as unsigned unless REQ-027 applies.
REQ-024 The trial subtraction SHALL be WIDTH+1 bits wide, with the MSB as borrow, so that no carry is lost for divisors ≥ 2^(WIDTH-1).

Reset
REQ-025 rst=1 at any rising edge SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
REQ-026 Reset SHALL take priority over start and SHALL abort a RUN in progress with no done pulse.

Configuration
REQ-027 With macro DIVIDER_SIGNED_EN defined, the block SHALL add input port is_signed (1 bit, captured on start).
- When is_signed=1, the block SHALL divide the operand magnitudes and then correct the signs.
- The quotient SHALL truncate toward zero.
- The remainder SHALL take the sign of the dividend.
- Divide-by-zero SHALL give quotient = all ones, remainder = dividend.
- The most-negative value divided by -1 SHALL give quotient 0x80000000, remainder 0, div_by_zero=0.
REQ-028 Without DIVIDER_SIGNED_EN, the is_signed port and all sign logic SHALL be absent, and the block SHALL be unsigned only.

Structure
REQ-029 A shared package/header SHALL hold:
- the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the default WIDTH;
- the counter width constant.
REQ-030 The one-iteration combinational step (shift, trial subtract, select) SHALL be a separate sub-module named div_step_32_bit, instantiated once.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- dividend=100, divisor=7, start for 1 cycle -> done 33 cycles later, quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; separately, dividend=5, divisor=0x80000000 -> quotient=0, remainder=5.
- divisor=0, dividend=0x1234 -> done 2 cycles after start, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- start during RUN with new operands -> ignored; the first operation's results appear at the original done cycle.
- rst asserted at RUN cycle 10 -> next cycle busy=0 and all outputs 0, no done pulse; a fresh 9/3 then gives quotient=3, remainder=0.
- with DIVIDER_SIGNED_EN, is_signed=1:
  - -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/restoring_divider_32_bit_pkg.sv
// Shared constants for the restoring divider: FSM encodings, default width and counter sizing.
// The optional signed mode is controlled by the DIVIDER_SIGNED_EN macro in the top-level file.
package restoring_divider_32_bit_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 32;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/restoring_divider_32_bit_step.sv
// One combinational restoring-division iteration: shift, trial subtract, select.
module div_step_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The partial remainder stays below the divisor, so after the shift it fits in WIDTH+1 bits
  // and the MSB of the WIDTH+1-bit difference is a reliable borrow.
  assign shifted_rem = {rem_in, quo_in[WIDTH-1]};
  assign diff        = shifted_rem - {1'b0, divisor};
  assign borrow      = diff[WIDTH];

  assign rem_out = borrow ? shifted_rem[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/restoring_divider_32_bit.sv
// Multi-cycle restoring divider, one quotient bit per clock, fixed latency.
// Define DIVIDER_SIGNED_EN to add the is_signed input and two's-complement sign correction.
module restoring_divider_32_bit
  import restoring_divider_32_bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] dividend_r;
  logic             dz_r;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] ds_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

`ifdef DIVIDER_SIGNED_EN
  logic dd_neg;
  logic ds_neg;
  logic neg_q;
  logic neg_r;

  // Divide magnitudes, then negate: quotient truncates toward zero, remainder follows the dividend.
  assign dd_neg  = is_signed & dividend[WIDTH-1];
  assign ds_neg  = is_signed & divisor[WIDTH-1];
  assign dd_mag  = dd_neg ? -dividend : dividend;
  assign ds_mag  = ds_neg ? -divisor : divisor;
  assign q_final = neg_q ? -quo_r : quo_r;
  assign r_final = neg_r ? -rem_r : rem_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dd_neg ^ ds_neg;
      neg_r <= dd_neg;
    end
  end
`else
  assign dd_mag  = dividend;
  assign ds_mag  = divisor;
  assign q_final = quo_r;
  assign r_final = rem_r;
`endif

  div_step_32_bit #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_r),
    .quo_in (quo_r),
    .divisor(divisor_r),
    .rem_out(rem_next),
    .quo_out(quo_next)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      dividend_r  <= '0;
      dz_r        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quo_r      <= dd_mag;
            divisor_r  <= ds_mag;
            dividend_r <= dividend;
            rem_r      <= '0;
            cnt        <= '0;
            dz_r       <= (divisor == '0);
            state      <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Results are published here so the done pulse and the new values appear together.
          done  <= 1'b1;
          state <= IDLE;
          if (dz_r) begin
            quotient    <= '1;
            remainder   <= dividend_r;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
